logic_unit_pipe: RTL
====================

# logic_unit_pipe

Parametrised, pipelined bitwise logic unit that supersedes the fixed 4-bit combinational gate block. It applies one of eight opcode-selected bitwise operations to two WIDTH-bit operands and registers the result through a two-stage valid/ready pipeline. It also produces result flags (zero, all-ones, parity, popcount) and a running count of delivered results. It sits between an operand source and a result consumer, either of which may stall.

## Interface
- WIDTH, 4, operand/result width in bits (≥1)
- CNT_W, 16, width of the delivered-result counter
- clk  input  1  rising-edge clock
- rst  input  1  synchronous, active-high reset
- in_valid  input  1  operand beat valid
- in_ready  output  1  unit accepts a beat this cycle
- in_a  input  WIDTH  operand A
- in_b  input  WIDTH  operand B
- in_op  input  3  opcode: 0 AND, 1 OR, 2 XOR, 3 NAND, 4 NOR, 5 XNOR, 6 NOT A, 7 PASS A
- out_valid  output  1  result beat valid
- out_ready  input  1  consumer accepts the result
- out_y  output  WIDTH  result
- out_zero  output  1  out_y == 0
- out_ones  output  1  out_y is all ones
- out_parity  output  1  XOR-reduction of out_y
- out_pop  output  $clog2(WIDTH+1)  number of set bits in out_y
- out_count  output  CNT_W  results delivered since reset

## Operation
- Stage 1 (S1): on accept (in_valid && in_ready), register op(in_a, in_b) into s1_y and set s1_valid.
- Stage 2 (S2): on advance, copy s1_y into out_y and register the flags computed from s1_y. Flags are registered, never combinational from out_y.
- Operations are bitwise only: no carries and no width growth. in_b is ignored for opcodes 6 and 7.
- Handshake: a beat transfers on a cycle where valid && ready are both high at the rising edge.
- in_valid, in_a, in_b and in_op must hold stable while in_valid && !in_ready. out_* hold stable while out_valid && !out_ready.
- Advance conditions:
  - s2_adv = s1_valid && (!out_valid || out_ready)
  - in_ready = !s1_valid || s2_adv (full throughput, no bubbles)
- S1 clear/load:
  - s1_valid clears when s2_adv occurs without a simultaneous accept.
  - If accept and s2_adv occur in the same cycle, S1 loads the new beat and S2 takes the old one.
- S2 clear: out_valid clears when out_valid && out_ready occur without s2_adv.
- out_count increments by 1 on each out_valid && out_ready. It wraps modulo 2^CNT_W with no saturation or flag.
- Stall: with out_ready low, at most two beats are held (S2 and S1). in_ready then drops low and no beat is lost or duplicated.

## Timing
- Reset (rst high at a clock edge) forces the following, regardless of any in-flight handshake:
  - s1_valid = 0, out_valid = 0
  - out_y = 0, out_zero = 1, out_ones = 0, out_parity = 0, out_pop = 0
  - out_count = 0
- in_ready is 1 in the first cycle after reset release.
- Latency: a beat accepted at edge N presents out_valid = 1 with its result after edge N+1, given no stall.
- Throughput: one beat per cycle while out_ready stays high.
- Reset mid-operation discards both stage contents. No result from before reset appears afterwards.
- Simultaneous accept, advance and output transfer in one cycle is legal and must update all three registers coherently.
- out_count wraps from 2^CNT_W−1 to 0 on the next transfer.

## Test plan
- Opcode sweep, WIDTH=4, a=1100, b=1010, out_ready=1: expect results AND 1000, OR 1110, XOR 0110, NAND 0111, NOR 0001, XNOR 1001, NOT A 0011, PASS A 1100. Each result appears 2 cycles after its accept; out_count ends at 8.
- Flags, WIDTH=4: a=0000 AND → zero=1, pop=0, parity=0; a=1111 PASS → ones=1, pop=4, parity=0; a=0111 PASS → pop=3, parity=1.
- Backpressure: stream 5 beats with out_ready=0. Expect in_ready to fall after 2 accepts. Raise out_ready and expect all 5 results in order, exactly once, with out_count=5.
- Random valid/ready: WIDTH=8, 1000 beats with random in_valid and out_ready. Scoreboard shows result order and values match the model, and out_count equals the number of transfers.
- Reset mid-stream: assert rst with both stages full. Expect the next cycle to show out_valid=0, in_ready=1, out_count=0, and no stale result afterwards.
- Counter wrap: CNT_W=3, 9 transfers → out_count = 1.

Source files
------------

// File: rtl/logic_unit_pipe.sv
// Two-stage valid/ready bitwise logic unit: S1 registers the selected operation,
// S2 registers the result plus its flags, and a counter tallies delivered results.
module logic_unit_pipe #(
    parameter int WIDTH = 4,
    parameter int CNT_W = 16
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         in_valid,
    output logic                         in_ready,
    input  logic [WIDTH-1:0]             in_a,
    input  logic [WIDTH-1:0]             in_b,
    input  logic [2:0]                   in_op,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic [WIDTH-1:0]             out_y,
    output logic                         out_zero,
    output logic                         out_ones,
    output logic                         out_parity,
    output logic [$clog2(WIDTH+1)-1:0]   out_pop,
    output logic [CNT_W-1:0]             out_count
);
    localparam int POP_W = $clog2(WIDTH + 1);

    function automatic logic bit_op(input logic [2:0] op, input logic a, input logic b);
        case (op)
            3'd0:    return a & b;
            3'd1:    return a | b;
            3'd2:    return a ^ b;
            3'd3:    return ~(a & b);
            3'd4:    return ~(a | b);
            3'd5:    return ~(a ^ b);
            3'd6:    return ~a;
            default: return a;
        endcase
    endfunction

    logic [WIDTH-1:0] op_y;
    logic             s1_valid_reg;
    logic [WIDTH-1:0] s1_y_reg;
    logic             out_valid_reg;
    logic [WIDTH-1:0] out_y_reg;
    logic             out_zero_reg;
    logic             out_ones_reg;
    logic             out_parity_reg;
    logic [POP_W-1:0] out_pop_reg;
    logic [CNT_W-1:0] count_reg;
    logic [POP_W-1:0] s1_pop;
    logic             accept;
    logic             s2_adv;
    logic             out_xfer;

    // Purely bitwise, so each result bit depends only on the same operand bits.
    for (genvar gi = 0; gi < WIDTH; gi++) begin : g_bit
        assign op_y[gi] = bit_op(in_op, in_a[gi], in_b[gi]);
    end

    always_comb begin
        s1_pop = '0;
        for (int i = 0; i < WIDTH; i++) begin
            s1_pop = s1_pop + POP_W'(s1_y_reg[i]);
        end
    end

    assign s2_adv   = s1_valid_reg && (!out_valid_reg || out_ready);
    assign in_ready = !s1_valid_reg || s2_adv;
    assign accept   = in_valid && in_ready;
    assign out_xfer = out_valid_reg && out_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid_reg <= 1'b0;
            s1_y_reg     <= '0;
        end else if (accept) begin
            s1_valid_reg <= 1'b1;
            s1_y_reg     <= op_y;
        end else if (s2_adv) begin
            s1_valid_reg <= 1'b0;
        end
    end

    // Flags are taken from s1_y so they land in the same cycle as out_y.
    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid_reg  <= 1'b0;
            out_y_reg      <= '0;
            out_zero_reg   <= 1'b1;
            out_ones_reg   <= 1'b0;
            out_parity_reg <= 1'b0;
            out_pop_reg    <= '0;
        end else if (s2_adv) begin
            out_valid_reg  <= 1'b1;
            out_y_reg      <= s1_y_reg;
            out_zero_reg   <= ~|s1_y_reg;
            out_ones_reg   <= &s1_y_reg;
            out_parity_reg <= ^s1_y_reg;
            out_pop_reg    <= s1_pop;
        end else if (out_xfer) begin
            out_valid_reg  <= 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            count_reg <= '0;
        end else if (out_xfer) begin
            count_reg <= count_reg + CNT_W'(1);
        end
    end

    assign out_valid  = out_valid_reg;
    assign out_y      = out_y_reg;
    assign out_zero   = out_zero_reg;
    assign out_ones   = out_ones_reg;
    assign out_parity = out_parity_reg;
    assign out_pop    = out_pop_reg;
    assign out_count  = count_reg;

endmodule
